// File: rtl/mbinit_param_pkg.sv
// Shared definitions for the MBINIT.PARAM responder: sideband message IDs,
// responder FSM states and the field layout of the parameter word.
package mbinit_param_pkg;

    localparam logic [3:0] MSG_CFG_REQ  = 4'b0001;
    localparam logic [3:0] MSG_CFG_RESP = 4'b0010;

    // Parameter word field layout
    localparam int unsigned RATE_LSB      = 0;
    localparam int unsigned RATE_W        = 4;
    localparam int unsigned SWING_LSB     = 4;
    localparam int unsigned SWING_W       = 5;
    localparam int unsigned CLK_MODE_BIT  = 9;
    localparam int unsigned CLK_PHASE_BIT = 10;
    localparam int unsigned MOD_ID_LSB    = 11;
    localparam int unsigned MOD_ID_W      = 2;
    localparam int unsigned X32_BIT       = 13;
    localparam int unsigned RSVD_LSB      = 14;
    localparam int unsigned RSVD_W        = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_REQ  = 3'd1,
        ST_RESOLVE   = 3'd2,
        ST_SEND_RESP = 3'd3,
        ST_DONE      = 3'd4,
        ST_ERROR     = 3'd5
    } param_rx_state_e;

endpackage

// File: rtl/mbinit_param_resolve.sv
// Combinational resolution of the partner's parameter word against local
// capabilities; flags words that carry no usable rate or swing.
module mbinit_param_resolve
    import mbinit_param_pkg::*;
#(
    parameter int unsigned PARAM_W = 16
) (
    input  logic [PARAM_W-1:0] param_word,
    input  logic [3:0]         local_max_rate,
    input  logic               local_clk_mode_cap,
    output logic [PARAM_W-1:0] resolved_word,
    output logic [3:0]         resolved_rate,
    output logic               invalid
);

    logic [RATE_W-1:0]  remote_rate_s;
    logic [SWING_W-1:0] remote_swing_s;
    logic [RATE_W-1:0]  min_rate_s;
    logic               unused_rsvd_s;

    // Reserved bits are never echoed back
    assign unused_rsvd_s = ^param_word[RSVD_LSB +: RSVD_W];

    // Field extraction, rate minimum and resolved word assembly
    always_comb begin
        remote_rate_s  = param_word[RATE_LSB +: RATE_W];
        remote_swing_s = param_word[SWING_LSB +: SWING_W];

        if (remote_rate_s < local_max_rate) begin
            min_rate_s = remote_rate_s;
        end else begin
            min_rate_s = local_max_rate;
        end

        resolved_word                              = {PARAM_W{1'b0}};
        resolved_word[RATE_LSB +: RATE_W]          = min_rate_s;
        resolved_word[SWING_LSB +: SWING_W]        = remote_swing_s;
        resolved_word[CLK_MODE_BIT]                = param_word[CLK_MODE_BIT] & local_clk_mode_cap;
        resolved_word[CLK_PHASE_BIT]               = param_word[CLK_PHASE_BIT];
        resolved_word[MOD_ID_LSB +: MOD_ID_W]      = param_word[MOD_ID_LSB +: MOD_ID_W];
        resolved_word[X32_BIT]                     = param_word[X32_BIT];

        resolved_rate = min_rate_s;
        invalid       = (remote_rate_s == {RATE_W{1'b0}}) || (remote_swing_s == {SWING_W{1'b0}});
    end

endmodule

// File: rtl/mbinit_param_rx.sv
// MBINIT.PARAM responder: waits for the partner's configuration request,
// resolves its parameter word and answers with a configuration response.
module mbinit_param_rx
    import mbinit_param_pkg::*;
#(
    parameter int unsigned          SB_MSG_Width   = 4,
    parameter int unsigned          PARAM_W        = 16,
    parameter int unsigned          TIMEOUT_W      = 20,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 20'd800000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_MBINIT_en,
    input  logic                    i_sb_busy,
    input  logic                    i_falling_edge_busy,
    input  logic                    i_sb_valid,
    input  logic [SB_MSG_Width-1:0] i_decoded_sb_msg,
    input  logic [PARAM_W-1:0]      i_rx_param,
    input  logic [3:0]              i_local_max_rate,
    input  logic                    i_local_clk_mode_cap,
    output logic [SB_MSG_Width-1:0] o_encoded_SB_msg,
    output logic                    o_msg_valid,
    output logic [PARAM_W-1:0]      o_tx_param,
    output logic [3:0]              o_resolved_rate,
    output logic                    o_PARAM_RX_end,
    output logic                    o_error_req
);

    localparam logic [SB_MSG_Width-1:0] REQ_ID_L  = SB_MSG_Width'(MSG_CFG_REQ);
    localparam logic [SB_MSG_Width-1:0] RESP_ID_L = SB_MSG_Width'(MSG_CFG_RESP);
    localparam logic [TIMEOUT_W-1:0]    CNT_ONE_L = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0]    CNT_LAST_L = TIMEOUT_CYCLES - CNT_ONE_L;

    param_rx_state_e        cs_r;
    param_rx_state_e        ns_s;
    logic [TIMEOUT_W-1:0]   timeout_cnt_r;
    logic [PARAM_W-1:0]     param_word_r;
    logic [PARAM_W-1:0]     resolved_word_s;
    logic [3:0]             resolved_rate_s;
    logic                   invalid_s;
    logic                   req_s;

    assign req_s = i_sb_valid && (i_decoded_sb_msg == REQ_ID_L);

    mbinit_param_resolve #(
        .PARAM_W (PARAM_W)
    ) u_resolve (
        .param_word         (param_word_r),
        .local_max_rate     (i_local_max_rate),
        .local_clk_mode_cap (i_local_clk_mode_cap),
        .resolved_word      (resolved_word_s),
        .resolved_rate      (resolved_rate_s),
        .invalid            (invalid_s)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cs_r <= ST_IDLE;
        end else begin
            cs_r <= ns_s;
        end
    end

    // Next-state logic; a request seen on the last timeout cycle still wins
    always_comb begin
        ns_s = cs_r;
        if (!i_MBINIT_en) begin
            ns_s = ST_IDLE;
        end else begin
            case (cs_r)
                ST_IDLE: begin
                    ns_s = ST_WAIT_REQ;
                end
                ST_WAIT_REQ: begin
                    if (req_s) begin
                        ns_s = ST_RESOLVE;
                    end else if (timeout_cnt_r == CNT_LAST_L) begin
                        ns_s = ST_ERROR;
                    end else begin
                        ns_s = ST_WAIT_REQ;
                    end
                end
                ST_RESOLVE: begin
                    if (invalid_s) begin
                        ns_s = ST_ERROR;
                    end else if (!i_sb_busy) begin
                        ns_s = ST_SEND_RESP;
                    end else begin
                        ns_s = ST_RESOLVE;
                    end
                end
                ST_SEND_RESP: begin
                    if (i_falling_edge_busy) begin
                        ns_s = ST_DONE;
                    end else begin
                        ns_s = ST_SEND_RESP;
                    end
                end
                ST_DONE:  ns_s = ST_DONE;
                ST_ERROR: ns_s = ST_ERROR;
                default:  ns_s = ST_IDLE;
            endcase
        end
    end

    // Wait-for-request timeout counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timeout_cnt_r <= {TIMEOUT_W{1'b0}};
        end else if (!i_MBINIT_en || (cs_r == ST_IDLE)) begin
            timeout_cnt_r <= {TIMEOUT_W{1'b0}};
        end else if (cs_r == ST_WAIT_REQ) begin
            timeout_cnt_r <= timeout_cnt_r + CNT_ONE_L;
        end else begin
            timeout_cnt_r <= timeout_cnt_r;
        end
    end

    // Partner parameter word, captured only from the first accepted request
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            param_word_r <= {PARAM_W{1'b0}};
        end else if (!i_MBINIT_en) begin
            param_word_r <= {PARAM_W{1'b0}};
        end else if ((cs_r == ST_WAIT_REQ) && req_s) begin
            param_word_r <= i_rx_param;
        end else begin
            param_word_r <= param_word_r;
        end
    end

    // Registered outputs decoded from the next state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_encoded_SB_msg <= {SB_MSG_Width{1'b0}};
            o_msg_valid      <= 1'b0;
            o_tx_param       <= {PARAM_W{1'b0}};
            o_PARAM_RX_end   <= 1'b0;
            o_error_req      <= 1'b0;
        end else if (ns_s == ST_SEND_RESP) begin
            o_encoded_SB_msg <= RESP_ID_L;
            o_msg_valid      <= 1'b1;
            o_tx_param       <= resolved_word_s;
            o_PARAM_RX_end   <= 1'b0;
            o_error_req      <= 1'b0;
        end else begin
            o_encoded_SB_msg <= {SB_MSG_Width{1'b0}};
            o_msg_valid      <= 1'b0;
            o_tx_param       <= {PARAM_W{1'b0}};
            o_PARAM_RX_end   <= (ns_s == ST_DONE);
            o_error_req      <= (ns_s == ST_ERROR);
        end
    end

    // Resolved rate is captured as the response goes out and held until disable
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_resolved_rate <= 4'd0;
        end else if (!i_MBINIT_en) begin
            o_resolved_rate <= 4'd0;
        end else if ((cs_r == ST_RESOLVE) && (ns_s == ST_SEND_RESP)) begin
            o_resolved_rate <= resolved_rate_s;
        end else begin
            o_resolved_rate <= o_resolved_rate;
        end
    end

endmodule

// File: tb/tb_mbinit_param_rx.sv
// Directed bench for the MBINIT.PARAM responder with hand-computed expectations.
module tb_mbinit_param_rx;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_MBINIT_en = 1'b0;
    logic        i_sb_busy = 1'b0;
    logic        i_falling_edge_busy = 1'b0;
    logic        i_sb_valid = 1'b0;
    logic [3:0]  i_decoded_sb_msg = 4'd0;
    logic [15:0] i_rx_param = 16'd0;
    logic [3:0]  i_local_max_rate = 4'd4;
    logic        i_local_clk_mode_cap = 1'b1;
    logic [3:0]  o_encoded_SB_msg;
    logic        o_msg_valid;
    logic [15:0] o_tx_param;
    logic [3:0]  o_resolved_rate;
    logic        o_PARAM_RX_end;
    logic        o_error_req;

    int vectors = 0;
    int miscompares = 0;

    mbinit_param_rx #(
        .SB_MSG_Width   (4),
        .PARAM_W        (16),
        .TIMEOUT_W      (20),
        .TIMEOUT_CYCLES (20'd16)
    ) dut (
        .i_clk                (i_clk),
        .i_rst_n              (i_rst_n),
        .i_MBINIT_en          (i_MBINIT_en),
        .i_sb_busy            (i_sb_busy),
        .i_falling_edge_busy  (i_falling_edge_busy),
        .i_sb_valid           (i_sb_valid),
        .i_decoded_sb_msg     (i_decoded_sb_msg),
        .i_rx_param           (i_rx_param),
        .i_local_max_rate     (i_local_max_rate),
        .i_local_clk_mode_cap (i_local_clk_mode_cap),
        .o_encoded_SB_msg     (o_encoded_SB_msg),
        .o_msg_valid          (o_msg_valid),
        .o_tx_param           (o_tx_param),
        .o_resolved_rate      (o_resolved_rate),
        .o_PARAM_RX_end       (o_PARAM_RX_end),
        .o_error_req          (o_error_req)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Drive a one-cycle message; returns one edge after it was sampled
    task automatic send_msg(input logic [3:0] id, input logic [15:0] word);
        i_sb_valid       = 1'b1;
        i_decoded_sb_msg = id;
        i_rx_param       = word;
        tick();
        i_sb_valid       = 1'b0;
        i_decoded_sb_msg = 4'd0;
        i_rx_param       = 16'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_msg"},   {28'd0, o_encoded_SB_msg}, 32'd0);
        check({tag, "_valid"}, {31'd0, o_msg_valid},      32'd0);
        check({tag, "_tx"},    {16'd0, o_tx_param},       32'd0);
        check({tag, "_rate"},  {28'd0, o_resolved_rate},  32'd0);
        check({tag, "_end"},   {31'd0, o_PARAM_RX_end},   32'd0);
        check({tag, "_err"},   {31'd0, o_error_req},      32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        check_all_zero("reset");
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();

        // Nominal exchange: remote rate 6 swing 5, local rate 4
        i_MBINIT_en = 1'b1;
        tick();
        send_msg(4'b0001, 16'h0856);
        check("nom_resolve_valid", {31'd0, o_msg_valid}, 32'd0);
        tick();
        check("nom_valid", {31'd0, o_msg_valid}, 32'd1);
        check("nom_msg", {28'd0, o_encoded_SB_msg}, 32'h2);
        check("nom_tx", {16'd0, o_tx_param}, 32'h0854);
        check("nom_rate", {28'd0, o_resolved_rate}, 32'd4);
        i_sb_busy = 1'b1;
        tick();
        check("nom_hold_valid", {31'd0, o_msg_valid}, 32'd1);
        i_sb_busy = 1'b0;
        i_falling_edge_busy = 1'b1;
        tick();
        i_falling_edge_busy = 1'b0;
        check("nom_end", {31'd0, o_PARAM_RX_end}, 32'd1);
        check("nom_done_valid", {31'd0, o_msg_valid}, 32'd0);
        check("nom_done_tx", {16'd0, o_tx_param}, 32'd0);
        check("nom_done_rate", {28'd0, o_resolved_rate}, 32'd4);
        // Duplicate request in DONE is ignored
        send_msg(4'b0001, 16'h0001);
        tick();
        check("dup_end", {31'd0, o_PARAM_RX_end}, 32'd1);
        check("dup_valid", {31'd0, o_msg_valid}, 32'd0);
        check("dup_rate", {28'd0, o_resolved_rate}, 32'd4);
        i_MBINIT_en = 1'b0;
        tick();
        check_all_zero("nom_disable");

        // Busy hold for 5 cycles after the request, then abort in SEND_RESP
        i_MBINIT_en = 1'b1;
        tick();
        i_sb_busy = 1'b1;
        send_msg(4'b0001, 16'h0856);
        check("busy_c1", {31'd0, o_msg_valid}, 32'd0);
        for (int i = 2; i <= 5; i++) begin
            tick();
            check("busy_hold", {31'd0, o_msg_valid}, 32'd0);
        end
        i_sb_busy = 1'b0;
        tick();
        check("busy_release_valid", {31'd0, o_msg_valid}, 32'd1);
        check("busy_release_tx", {16'd0, o_tx_param}, 32'h0854);
        i_MBINIT_en = 1'b0;
        tick();
        check_all_zero("abort_send");

        // Invalid word: rate field 0
        i_MBINIT_en = 1'b1;
        tick();
        send_msg(4'b0001, 16'h0850);
        tick();
        check("inv_err", {31'd0, o_error_req}, 32'd1);
        check("inv_valid", {31'd0, o_msg_valid}, 32'd0);
        tick();
        check("inv_err_hold", {31'd0, o_error_req}, 32'd1);
        check("inv_no_resp", {31'd0, o_msg_valid}, 32'd0);
        i_MBINIT_en = 1'b0;
        tick();
        check("inv_err_clear", {31'd0, o_error_req}, 32'd0);

        // Timeout with no request: error 16 edges after entering WAIT_REQ
        i_MBINIT_en = 1'b1;
        tick();
        repeat (15) tick();
        check("tmo_before", {31'd0, o_error_req}, 32'd0);
        tick();
        check("tmo_err", {31'd0, o_error_req}, 32'd1);
        i_MBINIT_en = 1'b0;
        tick();

        // Request on the last timeout cycle wins
        i_MBINIT_en = 1'b1;
        tick();
        repeat (15) tick();
        send_msg(4'b0001, 16'h0856);
        check("tmo_race_err", {31'd0, o_error_req}, 32'd0);
        tick();
        check("tmo_race_valid", {31'd0, o_msg_valid}, 32'd1);
        check("tmo_race_tx", {16'd0, o_tx_param}, 32'h0854);
        i_falling_edge_busy = 1'b1;
        tick();
        i_falling_edge_busy = 1'b0;
        check("tmo_race_end", {31'd0, o_PARAM_RX_end}, 32'd1);
        i_MBINIT_en = 1'b0;
        tick();

        // Clock mode with cap 0 clears bit 9
        i_local_clk_mode_cap = 1'b0;
        i_MBINIT_en = 1'b1;
        tick();
        send_msg(4'b0001, 16'h0256);
        tick();
        check("clk_cap0_tx", {16'd0, o_tx_param}, 32'h0054);
        i_MBINIT_en = 1'b0;
        tick();

        // Cap 1, local rate above remote, reserved bits zeroed
        i_local_clk_mode_cap = 1'b1;
        i_local_max_rate = 4'd8;
        i_MBINIT_en = 1'b1;
        tick();
        send_msg(4'b0001, 16'hFE56);
        tick();
        check("clk_cap1_tx", {16'd0, o_tx_param}, 32'h3E56);
        check("clk_cap1_rate", {28'd0, o_resolved_rate}, 32'd6);
        i_MBINIT_en = 1'b0;
        tick();
        i_local_max_rate = 4'd4;

        // Reset during RESOLVE, then no response until a new request
        i_MBINIT_en = 1'b1;
        tick();
        i_sb_busy = 1'b1;
        send_msg(4'b0001, 16'h0856);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("rst_resolve");
        tick();
        i_rst_n = 1'b1;
        i_sb_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_resp", {31'd0, o_msg_valid}, 32'd0);
        end
        send_msg(4'b0010, 16'h0856);
        tick();
        check("wrong_id_ignored", {31'd0, o_msg_valid}, 32'd0);
        send_msg(4'b0001, 16'h0856);
        tick();
        check("post_rst_valid", {31'd0, o_msg_valid}, 32'd1);
        // Asynchronous reset mid-SEND_RESP clears outputs immediately
        #2;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("rst_send");
        tick();
        i_rst_n = 1'b1;
        i_MBINIT_en = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mbinit_param_rx.md
# mbinit_param_rx

Responder side of the MBINIT.PARAM sideband exchange.
- Waits for the partner's `MBINIT_PARAM_configuration_req` and latches the partner's parameter word.
- Resolves that word against local capabilities.
- Returns `MBINIT_PARAM_configuration_resp` carrying the resolved word, then reports completion to the MBINIT sequencer. Runs alongside the initiator-side PARAM block under the same `i_MBINIT_en`.

## Interface
- `SB_MSG_Width`, 4, width of encoded/decoded sideband message IDs
- `PARAM_W`, 16, parameter word width
- `TIMEOUT_W`, 20, width of wait-for-request counter
- `TIMEOUT_CYCLES`, 20'd800000, cycles allowed in WAIT_REQ before error
- `i_clk` input 1 — single clock
- `i_rst_n` input 1 — reset, asynchronous, active-low
- `i_MBINIT_en` input 1 — PARAM phase enable; low forces IDLE
- `i_sb_busy` input 1 — sideband TX busy
- `i_falling_edge_busy` input 1 — one-cycle pulse, sideband TX finished a message
- `i_sb_valid` input 1 — decoded RX message valid (one cycle)
- `i_decoded_sb_msg` input SB_MSG_Width — decoded RX message ID
- `i_rx_param` input PARAM_W — data payload of the RX message, valid with `i_sb_valid`
- `i_local_max_rate` input 4 — local max data-rate code
- `i_local_clk_mode_cap` input 1 — local support for free-running clock mode
- `o_encoded_SB_msg` output SB_MSG_Width — message ID to sideband TX
- `o_msg_valid` output 1 — TX request
- `o_tx_param` output PARAM_W — resolved word sent with the response
- `o_resolved_rate` output 4 — resolved data-rate code, held after resolution
- `o_PARAM_RX_end` output 1 — responder phase complete
- `o_error_req` output 1 — request to trainer error handling

## Operation
- Message IDs: `configuration_req` = 4'b0001, `configuration_resp` = 4'b0010.
- Parameter word fields:
  - [3:0] max rate
  - [8:4] voltage swing
  - [9] clock mode
  - [10] clock phase
  - [12:11] module ID
  - [13] x32
  - [15:14] reserved
- Resolution, combinational on the latched word:
  - rate = min(remote, local)
  - swing, phase, module ID, x32: echoed from remote
  - clock mode = remote & `i_local_clk_mode_cap`
  - reserved = 0
  - Word is invalid if remote rate == 0 or swing == 0.
- FSM states: IDLE, WAIT_REQ, RESOLVE, SEND_RESP, DONE, ERROR.
  - IDLE → WAIT_REQ when `i_MBINIT_en`; the timeout counter clears.
  - WAIT_REQ: counter increments each cycle.
    - `i_sb_valid` && msg == req → latch `i_rx_param`, go to RESOLVE.
    - Otherwise, counter == TIMEOUT_CYCLES-1 → ERROR.
    - Request wins over timeout when both occur in the same cycle.
  - RESOLVE: invalid word → ERROR. Valid and `!i_sb_busy` → SEND_RESP. Valid and busy → stay.
  - SEND_RESP: `i_falling_edge_busy` → DONE.
  - DONE and ERROR: hold until `i_MBINIT_en` falls.
  - `!i_MBINIT_en` in any state → IDLE on the next edge. The counter clears; the latched word and `o_resolved_rate` clear to 0.
- Further `configuration_req` messages are ignored in RESOLVE, SEND_RESP, DONE and ERROR. Other message IDs are ignored in all states.

## Timing
- All outputs are registered and decoded from the next state, so they change on the same edge that CS enters the state.
- Reset values: all outputs 0, CS = IDLE, counter 0, latched word 0.
- `o_msg_valid` = 1, `o_encoded_SB_msg` = 4'b0010 and `o_tx_param` = resolved word throughout SEND_RESP. All three are 0 in every other state.
- `o_resolved_rate` updates on the RESOLVE→SEND_RESP edge and holds until disable.
- Best-case latency, req pulse at edge N:
  - edge N+1: CS = RESOLVE
  - edge N+2: CS = SEND_RESP, `o_msg_valid` high
- `o_PARAM_RX_end` is high from entry to DONE while enabled. `o_error_req` is high from entry to ERROR while enabled.
- Reset asserted mid-exchange clears everything asynchronously. No response is sent after reset release until a new request arrives.

## Structure
- Shared package `mbinit_param_pkg` holds:
  - message ID localparams
  - state enum
  - field offset/width localparams for the parameter word
- Sub-module `mbinit_param_resolve`: purely combinational. Inputs are the latched word and the local capabilities; outputs are the resolved word, resolved rate and invalid flag. It has no clock.
- Top module: FSM, timeout counter, latch register, output registers.

## Test plan
- Nominal exchange:
  - Stimulus: enable, req with param 16'h0856 (rate 6, swing 5), local rate 4, cap 1.
  - Required: `o_tx_param` = 16'h0854 with `o_msg_valid` two edges after the req. After the `i_falling_edge_busy` pulse, `o_PARAM_RX_end` = 1 and `o_resolved_rate` = 4.
- Busy hold: keep `i_sb_busy` = 1 for 5 cycles after the req → `o_msg_valid` stays 0 until busy drops, then rises the next edge.
- Invalid word: req with rate field 0 → `o_error_req` = 1 and no response is sent. Deasserting enable clears the error next edge.
- Timeout: TIMEOUT_CYCLES = 16 with no req → `o_error_req` rises 16 edges after entering WAIT_REQ. With the req on cycle 15, the response proceeds normally.
- Clock mode: remote bit 9 = 1 with cap 0 → response bit 9 = 0. With cap 1 → response bit 9 = 1.
- Abort: drop enable during SEND_RESP, or assert reset during RESOLVE → all outputs 0 next edge/immediately. A duplicate req in DONE is ignored.
